// File: rtl/pgm8755_pkg.sv
// Shared definitions for the 8755 programmer/reader: bus widths, default
// timing and the reader state encoding.
package pgm8755_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned TMR_W  = 8;

  localparam int unsigned DEF_DEPTH      = 2048;
  localparam int unsigned DEF_ALE_CYCLES = 4;
  localparam int unsigned DEF_RD_CYCLES  = 25;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    HOLD,
    READ,
    SEND,
    WAIT_BUSY,
    DRAIN,
    NEXT,
    CSUM
  } state_t;

  // The timer reaches zero after (load value + 1) cycles.
  function automatic logic [TMR_W-1:0] tmr_load(input int unsigned cycles);
    return TMR_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/eprom_reader_bus_timer.sv
// Loadable down-counter with zero flag; times the ALE and RD bus phases.
module bus_timer
  import pgm8755_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TMR_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/eprom_reader.sv
// 8755 EPROM dump engine: reads every location over the multiplexed AD bus
// and streams the bytes to the UART. EPROM_READER_CHECKSUM_EN appends a mod-256 sum byte.
module eprom_reader
  import pgm8755_pkg::*;
#(
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ALE_CYCLES = DEF_ALE_CYCLES,
  parameter int unsigned RD_CYCLES  = DEF_RD_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] ad_in,
  input  logic              tx_busy,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic [ADDR_W-1:0] addr,
  output logic              ale,
  output logic              rd_n,
  output logic              ce,
  output logic [DATA_W-1:0] tx_data,
  output logic              new_tx_data,
  output logic              active,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] ad_out_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              ad_oe_q;
  logic              ale_q;
  logic              rd_n_q;
  logic              new_tx_q;
  logic              active_q;
  logic              done_q;

  logic [ADDR_W-1:0] addr_inc;
  logic              dump_end;
  logic              timer_load;
  logic [TMR_W-1:0]  timer_val;
  logic              timer_zero;

`ifdef EPROM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic              csum_phase_q;
  assign dump_end = csum_phase_q;
`else
  assign dump_end = (addr_q == LAST_ADDR);
`endif

  assign addr_inc = addr_q + ADDR_W'(1);

  // Timer is loaded on the edge that enters ADDR or READ so the phase
  // lengths count from the first cycle the strobe is visible.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = tmr_load(ALE_CYCLES);
    case (state_q)
      IDLE: timer_load = start;
      NEXT: timer_load = 1'b1;
      HOLD: begin
        timer_load = 1'b1;
        timer_val  = tmr_load(RD_CYCLES);
      end
      default: ;
    endcase
  end

  bus_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .zero_o     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      ad_out_q  <= '0;
      tx_data_q <= '0;
      ad_oe_q   <= 1'b0;
      ale_q     <= 1'b0;
      rd_n_q    <= 1'b1;
      new_tx_q  <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef EPROM_READER_CHECKSUM_EN
      sum_q        <= '0;
      csum_phase_q <= 1'b0;
`endif
    end else begin
      new_tx_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= ADDR;
            addr_q   <= '0;
            ad_out_q <= '0;
            ad_oe_q  <= 1'b1;
            ale_q    <= 1'b1;
            active_q <= 1'b1;
`ifdef EPROM_READER_CHECKSUM_EN
            sum_q        <= '0;
            csum_phase_q <= 1'b0;
`endif
          end
        end
        ADDR: begin
          if (timer_zero) begin
            ale_q   <= 1'b0;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          ad_oe_q <= 1'b0;
          rd_n_q  <= 1'b0;
          state_q <= READ;
        end
        READ: begin
          if (timer_zero) begin
            rd_n_q    <= 1'b1;
            tx_data_q <= ad_in;
`ifdef EPROM_READER_CHECKSUM_EN
            sum_q <= sum_q + ad_in;
`endif
            state_q <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            new_tx_q <= 1'b1;
            state_q  <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!tx_busy) state_q <= NEXT;
        end
        NEXT: begin
`ifdef EPROM_READER_CHECKSUM_EN
          if (!csum_phase_q && addr_q == LAST_ADDR) begin
            state_q <= CSUM;
          end else
`endif
          if (dump_end) begin
            done_q   <= 1'b1;
            active_q <= 1'b0;
            addr_q   <= '0;
            state_q  <= IDLE;
          end else begin
            addr_q   <= addr_inc;
            ad_out_q <= addr_inc[DATA_W-1:0];
            ad_oe_q  <= 1'b1;
            ale_q    <= 1'b1;
            state_q  <= ADDR;
          end
        end
`ifdef EPROM_READER_CHECKSUM_EN
        CSUM: begin
          tx_data_q    <= sum_q;
          csum_phase_q <= 1'b1;
          state_q      <= SEND;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ad_out      = ad_out_q;
  assign ad_oe       = ad_oe_q;
  assign addr        = addr_q;
  assign ale         = ale_q;
  assign rd_n        = rd_n_q;
  assign ce          = 1'b0;
  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_q;
  assign active      = active_q;
  assign done        = done_q;

endmodule

// File: tb/tb_eprom_reader.sv
// Scoreboard bench for eprom_reader with EPROM and UART behavioural models.
module tb_eprom_reader;
  import pgm8755_pkg::*;

  localparam int unsigned DEPTH    = 1024;
  localparam int unsigned ALE_C    = 4;
  localparam int unsigned RD_C     = 25;
  localparam int unsigned BUSY_LEN = 4;
`ifdef EPROM_READER_CHECKSUM_EN
  localparam int unsigned N_BYTES = DEPTH + 1;
  localparam logic [7:0] FIRST [3] = '{8'h01, 8'h01, 8'h01};
`else
  localparam int unsigned N_BYTES = DEPTH;
  localparam logic [7:0] FIRST [3] = '{8'hA5, 8'hA4, 8'hA7};
`endif

  logic              clk;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] ad_in;
  logic              tx_busy;
  logic [DATA_W-1:0] ad_out;
  logic              ad_oe;
  logic [ADDR_W-1:0] addr;
  logic              ale;
  logic              rd_n;
  logic              ce;
  logic [DATA_W-1:0] tx_data;
  logic              new_tx_data;
  logic              active;
  logic              done;

  eprom_reader #(
    .DEPTH      (DEPTH),
    .ALE_CYCLES (ALE_C),
    .RD_CYCLES  (RD_C)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ad_in       (ad_in),
    .tx_busy     (tx_busy),
    .ad_out      (ad_out),
    .ad_oe       (ad_oe),
    .addr        (addr),
    .ale         (ale),
    .rd_n        (rd_n),
    .ce          (ce),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .active      (active),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rom(input logic [ADDR_W-1:0] a);
`ifdef EPROM_READER_CHECKSUM_EN
    return 8'h01 | {8{a[0] & 1'b0}};
`else
    return a[7:0] ^ 8'hA5;
`endif
  endfunction

  // UART: busy from the cycle after each pulse for BUSY_LEN cycles
  int unsigned busy_cnt;
  logic        hold_busy;
  always @(posedge clk) begin
    if (rst) busy_cnt <= 0;
    else if (new_tx_data) busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || hold_busy;

  // EPROM: latches the address while ALE is high, drives data while RD is low
  logic [ADDR_W-1:0] lat_addr;
  always @(posedge clk) begin
    if (ale) lat_addr <= {addr[10:8], ad_out};
  end
  assign ad_in = !rd_n ? rom(lat_addr) : 8'hEE;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned rx_total = 0;
  int unsigned done_cnt = 0;
  int unsigned dump_base = 0;

  task automatic push_dump();
    exp_t       e;
    logic [7:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      e.a = ADDR_W'(i);
      e.d = rom(ADDR_W'(i));
      sum = sum + e.d;
      exp_q.push_back(e);
    end
`ifdef EPROM_READER_CHECKSUM_EN
    e.a = ADDR_W'(DEPTH - 1);
    e.d = sum;
    exp_q.push_back(e);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rx(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned c;
    c = 0;
    while ((rx_total - dump_base) < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'((rx_total - dump_base) >= n), 32'd1);
  endtask

  task automatic wait_done(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned c;
    c = 0;
    while (done_cnt < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, done_cnt, n);
  endtask

  // Monitor: bus protocol, latency and scoreboard comparison
  initial begin
    logic        prev_ale, prev_rd_n, prev_ntx, prev_done, prev_active;
    logic        hold_chk, lat_valid, busy_seen;
    int unsigned ale_run, rd_run, lat_cnt, k;
    exp_t        e;
    prev_ale = 1'b0; prev_rd_n = 1'b1; prev_ntx = 1'b0; prev_done = 1'b0;
    prev_active = 1'b0; hold_chk = 1'b0; lat_valid = 1'b0; busy_seen = 1'b0;
    ale_run = 0; rd_run = 0; lat_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ale = 1'b0; prev_rd_n = 1'b1; prev_ntx = 1'b0; prev_done = 1'b0;
        prev_active = 1'b0; hold_chk = 1'b0; lat_valid = 1'b0;
      end else begin
        check("ale_rd_overlap", 32'(ale & ~rd_n), 32'd0);
        check("oe_rd_overlap", 32'(ad_oe & ~rd_n), 32'd0);
        if (ale) begin
          if (!prev_ale) begin
            ale_run = 1; lat_cnt = 0; lat_valid = 1'b1; busy_seen = 1'b0;
          end else begin
            ale_run++;
          end
          check("ale_oe", 32'(ad_oe), 32'd1);
          if (addr == 11'h3FF) begin
            check("ale_adlo_3ff", 32'(ad_out), 32'hFF);
            check("ale_ahi_3ff", 32'(addr[10:8]), 32'd3);
          end
        end else if (prev_ale) begin
          check("ale_width", ale_run, ALE_C);
          check("hold_oe", 32'(ad_oe), 32'd1);
          check("hold_rd", 32'(rd_n), 32'd1);
          if (exp_q.size() != 0) check("hold_addr", 32'({addr[10:8], ad_out}), 32'(exp_q[0].a));
          hold_chk = 1'b1;
        end else if (hold_chk) begin
          check("read_oe", 32'(ad_oe), 32'd0);
          check("read_rd", 32'(rd_n), 32'd0);
          hold_chk = 1'b0;
        end
        if (lat_valid && !(ale && !prev_ale)) lat_cnt++;
        if (tx_busy) busy_seen = 1'b1;
        if (!rd_n) rd_run = prev_rd_n ? 1 : rd_run + 1;
        else if (!prev_rd_n) check("rd_width", rd_run, RD_C);

        if (new_tx_data) begin
          rx_total++;
          k = rx_total - dump_base - 1;
          check("ntx_active", 32'(active), 32'd1);
          check("ntx_ce", 32'(ce), 32'd0);
          if (lat_valid && !busy_seen) check("latency", lat_cnt, ALE_C + 1 + RD_C + 1);
          lat_valid = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_byte_qdepth", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", 32'(tx_data), 32'(e.d));
            check("tx_addr", 32'(addr), 32'(e.a));
          end
          if (k < 3) check("first_bytes", 32'(tx_data), 32'(FIRST[2'(k)]));
        end
        if (prev_ntx) check("ntx_pulse", 32'(new_tx_data), 32'd0);

        if (done) begin
          done_cnt++;
          check("done_active", 32'(active), 32'd0);
          check("active_before_done", 32'(prev_active), 32'd1);
          check("done_bytes", rx_total - dump_base, N_BYTES);
          check("done_q_empty", 32'(exp_q.size()), 32'd0);
        end
        if (prev_done) check("done_pulse", 32'(done), 32'd0);

        prev_ale = ale; prev_rd_n = rd_n; prev_ntx = new_tx_data;
        prev_done = done; prev_active = active;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned c;
    rst = 1'b1;
    start = 1'b0;
    hold_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ad_out", 32'(ad_out), 32'd0);
    check("rst_ad_oe", 32'(ad_oe), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_ale", 32'(ale), 32'd0);
    check("rst_rd_n", 32'(rd_n), 32'd1);
    check("rst_ce", 32'(ce), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_ntx", 32'(new_tx_data), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Dump 1: UART busy for 200 cycles before the first byte, start re-pulsed at byte 100
    hold_busy = 1'b1;
    dump_base = rx_total;
    push_dump();
    pulse_start();
    check("start_active", 32'(active), 32'd1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("stall_ntx", 32'(new_tx_data), 32'd0);
      if (i >= 40) check("stall_hold_data", 32'(tx_data), 32'(FIRST[0]));
    end
    hold_busy = 1'b0;
    wait_rx(101, 6000, "reach_byte_100");
    pulse_start();
    check("restart_still_active", 32'(active), 32'd1);
    wait_done(1, 60000, "dump1_done");
    @(negedge clk);
    check("idle_addr_wrap", 32'(addr), 32'd0);
    check("idle_active", 32'(active), 32'd0);

    // Dump 2: reset in the READ phase of 0x200
    dump_base = rx_total;
    push_dump();
    pulse_start();
    c = 0;
    while (!(addr == 11'h200 && !rd_n) && c < 30000) begin
      @(negedge clk);
      c++;
    end
    check("reach_read_200", 32'(addr == 11'h200 && !rd_n), 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rd_n", 32'(rd_n), 32'd1);
    check("mid_rst_ad_oe", 32'(ad_oe), 32'd0);
    check("mid_rst_ale", 32'(ale), 32'd0);
    check("mid_rst_addr", 32'(addr), 32'd0);
    check("mid_rst_active", 32'(active), 32'd0);
    check("mid_rst_ntx", 32'(new_tx_data), 32'd0);
    check("mid_rst_bytes", rx_total - dump_base, 32'h200);
    check("mid_rst_q_left", 32'(exp_q.size()), N_BYTES - 32'h200);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("post_rst_ntx", 32'(new_tx_data), 32'd0);
    end

    // Dump 3: fresh start after reset begins at address 0
    dump_base = rx_total;
    push_dump();
    pulse_start();
    wait_rx(3, 500, "dump3_first3");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
